sti_rx: RTL

STI_RX -- requirements
Module: sti_rx

---
 rtl/sti_rx.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/sti_rx.sv
// Serial-to-parallel frame receiver: 8/16/24/32-bit serial frames
// reduced to a 16-bit payload with pad-bit checking and abort detection.
module sti_rx (
  input  logic        clk,
  input  logic        reset,
  input  logic        cfg_load,
  input  logic [1:0]  cfg_length,
  input  logic        cfg_fill,
  input  logic        cfg_msb,
  input  logic        cfg_low,
  input  logic        si_data,
  input  logic        si_valid,
  output logic [15:0] po_data,
  output logic        po_valid,
  output logic        po_pad_err,
  output logic        po_err,
  output logic        busy,
  output logic [7:0]  frame_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_RECV
  } state_t;

  state_t      r_state;
  logic [1:0]  r_len;
  logic        r_fill;
  logic        r_msb;
  logic        r_low;
  logic [5:0]  r_cnt;
  logic [31:0] r_sh;

  logic [31:0] w_sh;
  logic        w_last;
  logic [15:0] w_data;
  logic        w_pad;

  // MSB-first shifts up; LSB-first drops each bit at its own index,
  // so in both cases the frame word ends up right-aligned in w_sh.
  always_comb begin
    w_sh = r_sh;
    if (r_msb)
      w_sh = {r_sh[30:0], si_data};
    else
      w_sh[r_cnt[4:0]] = si_data;
  end

  assign w_last = (r_cnt[4:0] == {r_len, 3'b111});

  always_comb begin
    w_data = 16'h0000;
    w_pad  = 1'b0;
    unique case (r_len)
      2'd0: w_data = r_low ? {w_sh[7:0], 8'h00}
                           : {8'h00, w_sh[7:0]};
      2'd1: w_data = w_sh[15:0];
      2'd2: begin
        if (r_fill) begin
          w_data = w_sh[23:8];
          w_pad  = |w_sh[7:0];
        end else begin
          w_data = w_sh[15:0];
          w_pad  = |w_sh[23:16];
        end
      end
      2'd3: begin
        if (r_fill) begin
          w_data = w_sh[31:16];
          w_pad  = |w_sh[15:0];
        end else begin
          w_data = w_sh[15:0];
          w_pad  = |w_sh[31:16];
        end
      end
      default: w_data = 16'h0000;
    endcase
  end

  assign busy = (r_state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_len      <= 2'd0;
      r_fill     <= 1'b0;
      r_msb      <= 1'b0;
      r_low      <= 1'b0;
      r_cnt      <= 6'd0;
      r_sh       <= 32'h0;
      po_data    <= 16'h0000;
      po_valid   <= 1'b0;
      po_pad_err <= 1'b0;
      po_err     <= 1'b0;
      frame_cnt  <= 8'd0;
    end else begin
      po_valid   <= 1'b0;
      po_pad_err <= 1'b0;
      po_err     <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (cfg_load) begin
            r_len   <= cfg_length;
            r_fill  <= cfg_fill;
            r_msb   <= cfg_msb;
            r_low   <= cfg_low;
            r_cnt   <= 6'd0;
            r_sh    <= 32'h0;
            r_state <= S_ARMED;
          end
        end
        S_ARMED: begin
          if (si_valid) begin
            r_sh    <= w_sh;
            r_cnt   <= 6'd1;
            r_state <= S_RECV;
          end
        end
        S_RECV: begin
          if (!si_valid) begin
            po_err  <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_sh  <= w_sh;
            r_cnt <= r_cnt + 6'd1;
            if (w_last) begin
              po_data    <= w_data;
              po_pad_err <= w_pad;
              po_valid   <= 1'b1;
              frame_cnt  <= frame_cnt + 8'd1;
              r_state    <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
